// File: rtl/axe_mailbox_pkg.sv
// axe_mailbox_pkg: FSM states, address field positions and AXI response codes shared by the task mailbox
// and the self-awareness initiators that poll it.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
package axe_mailbox_pkg;
    localparam int AXI_DATA_WIDTH = 32;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam int REGION_BIT = `AXI_ADDR_WIDTH - 1;
    localparam int SLOT_BIT = 7;
    localparam int NODE_HI = 6;
    localparam int NODE_LO = 2;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    function automatic logic [4:0] node_of(input logic [`AXI_ADDR_WIDTH-1:0] addr);
        return addr[NODE_HI:NODE_LO];
    endfunction
endpackage

// File: rtl/if_axi_light.sv
// if_axi_light: AXI-lite bundle with 32-bit data and `AXI_ADDR_WIDTH-bit addresses.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
interface if_axi_light;
    logic [`AXI_ADDR_WIDTH-1:0] awaddr;
    logic awvalid;
    logic awready;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic wvalid;
    logic wready;
    logic [1:0] bresp;
    logic bvalid;
    logic bready;
    logic [`AXI_ADDR_WIDTH-1:0] araddr;
    logic arvalid;
    logic arready;
    logic [31:0] rdata;
    logic [1:0] rresp;
    logic rvalid;
    logic rready;
    modport slave(
        input awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport master(
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/mailbox_slot_file.sv
// mailbox_slot_file: per-node task address slots, busy mask and, with TASK_MAILBOX_STATS_EN,
// a 16-bit wrapping completion counter per slot.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
module mailbox_slot_file #(
    parameter int NODE_COUNT = 32,
    parameter int AW = `AXI_ADDR_WIDTH
) (
    input logic clk,
    input logic res_n,
    input logic wr_en,
    input logic [4:0] wr_node,
    input logic [AW-1:0] wr_value,
    input logic done,
    input logic asg_en,
    input logic [4:0] asg_node,
    input logic [AW-1:0] asg_value,
    input logic [4:0] rd_node,
    output logic [AW-1:0] rd_value,
`ifdef TASK_MAILBOX_STATS_EN
    output logic [15:0] rd_count,
`endif
    output logic [NODE_COUNT-1:0] busy_mask
);
    logic [AW-1:0] slots [NODE_COUNT];
    // The owner arbitrates so AXI and assign never target the same slot in one cycle.
    always_ff @(posedge clk)
        for (int i = 0; i < NODE_COUNT; i++)
            if (!res_n) slots[i] <= '0;
            else if (wr_en && wr_node == 5'(i)) slots[i] <= wr_value;
            else if (asg_en && asg_node == 5'(i)) slots[i] <= asg_value;
    always_comb begin
        rd_value = '0;
        for (int i = 0; i < NODE_COUNT; i++) begin
            busy_mask[i] = |slots[i];
            if (rd_node == 5'(i)) rd_value = slots[i];
        end
    end
`ifdef TASK_MAILBOX_STATS_EN
    logic [15:0] counts [NODE_COUNT];
    always_ff @(posedge clk)
        for (int i = 0; i < NODE_COUNT; i++)
            if (!res_n) counts[i] <= '0;
            else if (done && wr_node == 5'(i)) counts[i] <= counts[i] + 16'd1;
    always_comb begin
        rd_count = '0;
        for (int i = 0; i < NODE_COUNT; i++)
            if (rd_node == 5'(i)) rd_count = counts[i];
    end
`endif
endmodule

// File: rtl/task_mailbox.sv
// task_mailbox: host-to-node task dispatch slots polled over AXI-lite; a node writes 0 to report completion.
// Optional per-slot completion counters are built when TASK_MAILBOX_STATS_EN is defined.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
module task_mailbox
    import axe_mailbox_pkg::*;
#(
    parameter int NODE_COUNT = 32
) (
    input logic clk,
    input logic res_n,
    if_axi_light.slave s_axi,
    input logic assign_valid,
    output logic assign_ready,
    input logic [4:0] assign_node,
    input logic [`AXI_ADDR_WIDTH-1:0] assign_addr,
    output logic done_valid,
    output logic [4:0] done_node,
    output logic [NODE_COUNT-1:0] busy_mask
);
    localparam int AW = `AXI_ADDR_WIDTH;
    logic [0:0] r_state, w_state;
    logic [4:0] ar_node, aw_node;
    logic ar_slot, aw_slot, wr_hs, wr_ok, wr_clear, asg_hs, aw_busy, asg_busy;
    logic [AW-1:0] rd_value;
    logic [AXI_DATA_WIDTH-1:0] r_data, rd_word;
    logic [1:0] r_resp, rd_resp, b_resp;
    logic unused_addr;
    assign ar_node = node_of(s_axi.araddr);
    assign aw_node = node_of(s_axi.awaddr);
    assign ar_slot = s_axi.araddr[REGION_BIT] && s_axi.araddr[SLOT_BIT] && int'(ar_node) < NODE_COUNT;
    assign aw_slot = s_axi.awaddr[REGION_BIT] && s_axi.awaddr[SLOT_BIT] && int'(aw_node) < NODE_COUNT;
    assign wr_hs = res_n && w_state == W_IDLE && s_axi.awvalid && s_axi.wvalid;
    assign wr_ok = wr_hs && aw_slot && &s_axi.wstrb;
    assign wr_clear = wr_ok && s_axi.wdata == '0 && aw_busy;
    // An AXI write decoded to the assign target blocks the dispatch for that cycle.
    assign assign_ready = res_n && int'(assign_node) < NODE_COUNT && !asg_busy
        && !(wr_hs && aw_slot && aw_node == assign_node);
    assign asg_hs = assign_valid && assign_ready;
    assign s_axi.arready = !res_n || r_state == R_IDLE;
    assign s_axi.awready = wr_hs;
    assign s_axi.wready = wr_hs;
    assign s_axi.rvalid = r_state == R_RESP;
    assign s_axi.bvalid = w_state == W_RESP;
    assign s_axi.rdata = r_data;
    assign s_axi.rresp = r_resp;
    assign s_axi.bresp = b_resp;
    assign unused_addr = ^{s_axi.araddr[AW-2:SLOT_BIT+1], s_axi.araddr[NODE_LO-1:0],
        s_axi.awaddr[AW-2:SLOT_BIT+1], s_axi.awaddr[NODE_LO-1:0]};
    always_comb begin
        aw_busy = 1'b0;
        asg_busy = 1'b0;
        for (int i = 0; i < NODE_COUNT; i++) begin
            if (aw_node == 5'(i)) aw_busy = busy_mask[i];
            if (assign_node == 5'(i)) asg_busy = busy_mask[i];
        end
    end
`ifdef TASK_MAILBOX_STATS_EN
    logic [15:0] rd_count;
    logic ar_stat;
    assign ar_stat = s_axi.araddr[REGION_BIT] && !s_axi.araddr[SLOT_BIT] && int'(ar_node) < NODE_COUNT;
`endif
    always_comb begin
        rd_word = ar_slot ? AXI_DATA_WIDTH'(rd_value) : '0;
        rd_resp = ar_slot ? RESP_OKAY : RESP_SLVERR;
`ifdef TASK_MAILBOX_STATS_EN
        rd_word = ar_stat ? AXI_DATA_WIDTH'(rd_count) : rd_word;
        rd_resp = ar_stat ? RESP_OKAY : rd_resp;
`endif
    end
    // Read data is captured at the handshake, so a same-cycle clearing write returns the old value.
    always_ff @(posedge clk)
        if (!res_n) begin
            r_state <= R_IDLE;
            r_data <= '0;
            r_resp <= RESP_OKAY;
        end else if (r_state == R_IDLE && s_axi.arvalid) begin
            r_state <= R_RESP;
            r_data <= rd_word;
            r_resp <= rd_resp;
        end else if (r_state == R_RESP && s_axi.rready) r_state <= R_IDLE;
    always_ff @(posedge clk)
        if (!res_n) begin
            w_state <= W_IDLE;
            b_resp <= RESP_OKAY;
            done_valid <= 1'b0;
            done_node <= '0;
        end else begin
            done_valid <= wr_clear;
            if (wr_clear) done_node <= aw_node;
            if (wr_hs) begin
                w_state <= W_RESP;
                b_resp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (w_state == W_RESP && s_axi.bready) w_state <= W_IDLE;
        end
    mailbox_slot_file #(.NODE_COUNT(NODE_COUNT), .AW(AW)) u_slots (
        .clk(clk),
        .res_n(res_n),
        .wr_en(wr_ok),
        .wr_node(aw_node),
        .wr_value(AW'(s_axi.wdata)),
        .done(wr_clear),
        .asg_en(asg_hs),
        .asg_node(assign_node),
        .asg_value(assign_addr),
        .rd_node(ar_node),
        .rd_value(rd_value),
`ifdef TASK_MAILBOX_STATS_EN
        .rd_count(rd_count),
`endif
        .busy_mask(busy_mask)
    );
endmodule

// File: tb/tb_task_mailbox.sv
// tb_task_mailbox: directed and randomized checks of task_mailbox against an array-based slot model.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
module tb_task_mailbox;
    localparam int NC = 24;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic res_n;
    logic assign_valid;
    logic assign_ready;
    logic [4:0] assign_node;
    logic [31:0] assign_addr;
    logic done_valid;
    logic [4:0] done_node;
    logic [NC-1:0] busy_mask;
    if_axi_light axi();
    task_mailbox #(.NODE_COUNT(NC)) dut (
        .clk(clk),
        .res_n(res_n),
        .s_axi(axi),
        .assign_valid(assign_valid),
        .assign_ready(assign_ready),
        .assign_node(assign_node),
        .assign_addr(assign_addr),
        .done_valid(done_valid),
        .done_node(done_node),
        .busy_mask(busy_mask)
    );
    int checks = 0;
    int passes = 0;
    int fails = 0;
    logic [31:0] m_slot [32];
    logic [15:0] m_cnt [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] slot_addr(input int node);
        return 32'h8000_0080 | 32'(node << 2);
    endfunction

    function automatic logic [31:0] stat_addr(input int node);
        return 32'h8000_0000 | 32'(node << 2);
    endfunction

    task automatic chk_mask();
        logic [NC-1:0] m;
        for (int i = 0; i < NC; i++) m[i] = m_slot[i] != 0;
        chk("busy_mask", 32'(busy_mask), 32'(m));
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        axi.araddr = addr;
        axi.arvalid = 1'b1;
        #1;
        while (!axi.arready && n < 20) begin tick(); n++; end
        tick();
        axi.arvalid = 1'b0;
        while (!axi.rvalid && n < 20) begin tick(); n++; end
        chk("read_timeout", 32'(n < 20), 32'd1);
        d = axi.rdata;
        r = axi.rresp;
        axi.rready = 1'b1;
        tick();
        axi.rready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] r, output logic dv, output logic [4:0] dn);
        int n = 0;
        axi.awaddr = addr;
        axi.wdata = data;
        axi.wstrb = strb;
        axi.awvalid = 1'b1;
        axi.wvalid = 1'b1;
        #1;
        while (!axi.awready && n < 20) begin tick(); n++; end
        tick();
        axi.awvalid = 1'b0;
        axi.wvalid = 1'b0;
        dv = done_valid;
        dn = done_node;
        while (!axi.bvalid && n < 20) begin tick(); n++; end
        chk("write_timeout", 32'(n < 20), 32'd1);
        r = axi.bresp;
        axi.bready = 1'b1;
        tick();
        axi.bready = 1'b0;
        chk("done_one_cycle", 32'(done_valid), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr);
        logic [31:0] d, ed;
        logic [1:0] r, er;
        int node;
        node = int'(addr[6:2]);
        er = 2'b10;
        ed = 32'd0;
        if (addr[31] && node < NC) begin
            if (addr[7]) begin er = 2'b00; ed = m_slot[node]; end
`ifdef TASK_MAILBOX_STATS_EN
            else begin er = 2'b00; ed = {16'd0, m_cnt[node]}; end
`endif
        end
        axi_read(addr, d, r);
        chk("rresp", 32'(r), 32'(er));
        if (er == 2'b00) chk("rdata", d, ed);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [1:0] r;
        logic dv;
        logic [4:0] dn;
        int node;
        bit ok, clr;
        node = int'(addr[6:2]);
        ok = addr[31] && addr[7] && node < NC && strb == 4'hF;
        clr = ok && data == 0 && m_slot[node] != 0;
        axi_write(addr, data, strb, r, dv, dn);
        chk("bresp", 32'(r), ok ? 32'd0 : 32'd2);
        chk("done_valid", 32'(dv), 32'(clr));
        if (clr) begin
            chk("done_node", 32'(dn), 32'(node));
            m_cnt[node]++;
        end
        if (ok) m_slot[node] = data;
    endtask

    task automatic do_assign(input int node, input logic [31:0] a);
        bit exp;
        exp = node < NC && m_slot[node] == 0;
        assign_valid = 1'b1;
        assign_node = 5'(node);
        assign_addr = a;
        #1;
        chk("assign_ready", 32'(assign_ready), 32'(exp));
        tick();
        assign_valid = 1'b0;
        if (exp) m_slot[node] = a;
    endtask

    initial begin
        logic [31:0] held;
        res_n = 1'b0;
        assign_valid = 1'b0;
        assign_node = '0;
        assign_addr = '0;
        axi.awaddr = '0;
        axi.awvalid = 1'b0;
        axi.wdata = '0;
        axi.wstrb = '0;
        axi.wvalid = 1'b0;
        axi.bready = 1'b0;
        axi.araddr = '0;
        axi.arvalid = 1'b0;
        axi.rready = 1'b0;
        for (int i = 0; i < 32; i++) begin m_slot[i] = '0; m_cnt[i] = '0; end
        tick();
        tick();
        chk("rst_arready", 32'(axi.arready), 32'd1);
        chk("rst_awready", 32'(axi.awready), 32'd0);
        chk("rst_rvalid", 32'(axi.rvalid), 32'd0);
        chk("rst_bvalid", 32'(axi.bvalid), 32'd0);
        chk("rst_rdata", axi.rdata, 32'd0);
        chk("rst_assign_ready", 32'(assign_ready), 32'd0);
        chk("rst_done", 32'({done_valid, done_node}), 32'd0);
        chk("rst_busy", 32'(busy_mask), 32'd0);
        res_n = 1'b1;
        tick();
        // dispatch then poll node 3
        do_assign(3, 32'h0001_0000);
        do_read(32'h8000_008C);
        chk("busy3_set", 32'(busy_mask[3]), 32'd1);
        // completion clears the slot
        do_write(32'h8000_008C, 32'd0, 4'hF);
        do_read(32'h8000_008C);
        chk("busy3_clr", 32'(busy_mask[3]), 32'd0);
        // assign and clearing write on a full slot in the same cycle
        do_assign(3, 32'h0000_2222);
        axi.awaddr = slot_addr(3);
        axi.wdata = 32'd0;
        axi.wstrb = 4'hF;
        axi.awvalid = 1'b1;
        axi.wvalid = 1'b1;
        assign_valid = 1'b1;
        assign_node = 5'd3;
        assign_addr = 32'h0000_3333;
        #1;
        chk("collide_assign_ready", 32'(assign_ready), 32'd0);
        tick();
        axi.awvalid = 1'b0;
        axi.wvalid = 1'b0;
        chk("collide_done", 32'({done_valid, done_node}), 32'h23);
        chk("collide_assign_next", 32'(assign_ready), 32'd1);
        axi.bready = 1'b1;
        tick();
        assign_valid = 1'b0;
        axi.bready = 1'b0;
        m_cnt[3]++;
        m_slot[3] = 32'h0000_3333;
        do_read(slot_addr(3));
        // nonzero write to an empty slot beats a same-cycle assign
        axi.awaddr = slot_addr(5);
        axi.wdata = 32'h0000_0ABC;
        axi.awvalid = 1'b1;
        axi.wvalid = 1'b1;
        assign_valid = 1'b1;
        assign_node = 5'd5;
        assign_addr = 32'h0000_0555;
        #1;
        chk("write_wins", 32'(assign_ready), 32'd0);
        tick();
        axi.awvalid = 1'b0;
        axi.wvalid = 1'b0;
        assign_valid = 1'b0;
        axi.bready = 1'b1;
        tick();
        axi.bready = 1'b0;
        m_slot[5] = 32'h0000_0ABC;
        do_read(slot_addr(5));
        // read and clear of one slot in the same cycle returns the old value
        axi.araddr = slot_addr(5);
        axi.arvalid = 1'b1;
        axi.awaddr = slot_addr(5);
        axi.wdata = 32'd0;
        axi.awvalid = 1'b1;
        axi.wvalid = 1'b1;
        tick();
        axi.arvalid = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid = 1'b0;
        chk("rw_same_rdata", axi.rdata, 32'h0000_0ABC);
        chk("rw_same_done", 32'({done_valid, done_node}), 32'h25);
        axi.rready = 1'b1;
        axi.bready = 1'b1;
        tick();
        axi.rready = 1'b0;
        axi.bready = 1'b0;
        m_slot[5] = 32'd0;
        m_cnt[5]++;
        // decode errors and partial strobes
        do_read(32'h0000_008C);
        do_write(32'h8000_008C, 32'd0, 4'h3);
        do_read(32'h8000_008C);
        do_read(slot_addr(28));
        do_assign(28, 32'h0000_0100);
        do_write(stat_addr(1), 32'd5, 4'hF);
        // three completions on node 1
        for (int k = 0; k < 3; k++) begin
            do_assign(1, 32'h0000_0100 + 32'(k));
            do_write(slot_addr(1), 32'd0, 4'hF);
        end
        do_read(32'h8000_0004);
        chk_mask();
        // randomized traffic
        for (int it = 0; it < 300; it++) begin
            int op, node;
            logic [31:0] a, d;
            op = int'($urandom_range(0, 2));
            node = int'($urandom_range(0, 31));
            d = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
            a = {$urandom_range(0, 5) != 0, 23'($urandom), $urandom_range(0, 4) != 0, 5'(node), 2'($urandom)};
            if (op == 0) do_assign(node, d);
            else if (op == 1) do_write(a, d, ($urandom_range(0, 5) == 0) ? 4'h3 : 4'hF);
            else do_read(a);
            chk_mask();
        end
        // stalled read response, then reset mid-transaction
        m_slot[3] = 32'h0000_7777;
        axi.awaddr = slot_addr(3);
        axi.wdata = 32'h0000_7777;
        axi.wstrb = 4'hF;
        axi.awvalid = 1'b1;
        axi.wvalid = 1'b1;
        tick();
        axi.awvalid = 1'b0;
        axi.wvalid = 1'b0;
        axi.bready = 1'b1;
        tick();
        axi.bready = 1'b0;
        axi.araddr = slot_addr(3);
        axi.arvalid = 1'b1;
        tick();
        axi.arvalid = 1'b0;
        held = axi.rdata;
        chk("stall_rdata", held, m_slot[3]);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_stable", axi.rdata, held);
            chk("stall_arready", 32'({axi.arready, axi.rvalid}), 32'd1);
        end
        res_n = 1'b0;
        tick();
        chk("mid_rst_rvalid", 32'(axi.rvalid), 32'd0);
        chk("mid_rst_busy", 32'(busy_mask), 32'd0);
        res_n = 1'b1;
        for (int i = 0; i < 32; i++) begin m_slot[i] = '0; m_cnt[i] = '0; end
        tick();
        do_read(slot_addr(3));
        do_read(slot_addr(1));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/task_mailbox.md
TASK_MAILBOX -- requirements
Module: task_mailbox

Interface
REQ-001 SHALL have parameter NODE_COUNT, default 32, number of node slots (1..32).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port res_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port s_axi  if_axi_light.slave  -  AXI-lite responder polled by node self-awareness initiators.
REQ-005 SHALL have port assign_valid  input  1  host requests a task dispatch.
REQ-006 SHALL have port assign_ready  output  1  dispatch accepted this cycle when high with assign_valid.
REQ-007 SHALL have port assign_node  input  5  target node id.
REQ-008 SHALL have port assign_addr  input  `AXI_ADDR_WIDTH  task base address (offset handed to node).
REQ-009 SHALL have port done_valid  output  1  one-cycle pulse: a node reported completion.
REQ-010 SHALL have port done_node  output  5  node id qualified by done_valid.
REQ-011 SHALL have port busy_mask  output  NODE_COUNT  bit n high while slot n holds a nonzero address.

Function
REQ-012 SHALL decode a slot access when addr bit `AXI_ADDR_WIDTH-1 = 1, bit 7 = 1, node id = addr[6:2] < NODE_COUNT; any other address answers SLVERR (2'b10), no state change.
REQ-013 SHALL run a read FSM R_IDLE -> R_RESP: arready high in R_IDLE; on arvalid handshake latch address, next cycle rvalid=1 with rdata = slot value (0 if empty), rresp OKAY; hold rdata/rresp until rready, then R_IDLE.
REQ-014 SHALL run a write FSM W_IDLE -> W_RESP: awready and wready both high in W_IDLE only when awvalid and wvalid are both high; accept both in one cycle; bvalid next cycle, held until bready.
REQ-015 SHALL reject writes with wstrb not all-ones with SLVERR and no slot change.
REQ-016 SHALL, on a valid write of wdata 0 to a nonzero slot, clear the slot and pulse done_valid with done_node the cycle after the AW/W handshake.
REQ-017 SHALL, on a valid write of 0 to an empty slot, respond OKAY without a done pulse; nonzero wdata overwrites the slot, no done pulse.
REQ-018 SHALL drive assign_ready = assign_valid-independent: high when slot[assign_node] is empty, assign_node < NODE_COUNT, and no AXI write to that slot is accepted in the same cycle (AXI write wins).
REQ-019 SHALL load assign_addr into the slot on assign handshake, visible to a read accepted the following cycle; assign_addr 0 is accepted as a no-op.
REQ-020 SHALL service read, write and assign in the same cycle independently; a read and a clearing write to one slot in the same cycle returns the pre-write value.
REQ-021 SHALL keep read and write channels single-outstanding; AR/AW are not accepted while the respective response is pending.

Reset
REQ-022 SHALL, while res_n = 0 at a clk edge, clear all slots and force arready=1, awready=0, wready=0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0, assign_ready=0, done_valid=0, done_node=0, busy_mask=0, FSMs to R_IDLE/W_IDLE.
REQ-023 SHALL abandon any pending response on reset mid-transaction without completing it.

Configuration
REQ-024 SHALL, with TASK_MAILBOX_STATS_EN defined, keep a 16-bit wrapping completion counter per slot, incremented on each done pulse, readable (zero-extended, OKAY) when addr bit MSB = 1, bit 7 = 0, id in addr[6:2]; writes there return SLVERR.
REQ-025 SHALL, without TASK_MAILBOX_STATS_EN, contain no counters and answer that region with SLVERR.

Structure
REQ-026 SHALL place the read/write state enums, control/prog bit indices, node-id field bounds and AXI resp codes in shared package axe_mailbox_pkg, reused by self_awareness-side code.
REQ-027 SHALL implement slot storage, busy_mask and optional counters in one sub-module mailbox_slot_file; AXI FSMs and arbitration stay in task_mailbox.

Verification
REQ-028 SHALL test: assign node 3 addr 0x0001_0000, AXI read 0x8000_008C -> rdata 0x0001_0000, OKAY, busy_mask[3]=1.
REQ-029 SHALL test: write 0 to 0x8000_008C -> bresp OKAY, done_valid one cycle with done_node 3, then read returns 0, busy_mask[3]=0.
REQ-030 SHALL test: assign to node 3 and AXI write 0 to node 3 same cycle on a full slot -> assign_ready 0, done pulse, then assign accepted next cycle.
REQ-031 SHALL test: read 0x0000_008C and write with wstrb 4'h3 -> SLVERR, slots unchanged, no done pulse.
REQ-032 SHALL test: hold rready low 5 cycles -> rdata stable, arready low; assert res_n low mid-wait -> rvalid 0, all slots 0 next cycle.
REQ-033 SHALL test (TASK_MAILBOX_STATS_EN): 3 completions on node 1 -> read 0x8000_0004 returns 3; without macro -> SLVERR.
